// File: rtl/fp_norm_round.sv
// fp_norm_round: 3-stage normalize / round-to-nearest-even stage behind the mantissa adder.
// Define FP_NORM_OVF_SAT_EN to saturate overflow to the largest finite value instead of infinity.
module fp_norm_round #(
  parameter int SUM_W  = 51,
  parameter int FRAC_W = 48,
  parameter int EXP_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_carry,
  input  logic [SUM_W-1:0]  in_sum,
  input  logic              in_sticky,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [FRAC_W-1:0] out_frac,
  output logic              out_ovf,
  output logic              out_uf,
  output logic              out_inexact
);
  localparam int LZC_W = $clog2(SUM_W + 1);
  localparam int XW    = EXP_W + 1;
  localparam logic [XW-1:0] EXP_INF = {1'b0, {EXP_W{1'b1}}};

  // Pipeline control: each stage loads when empty or when its contents move on.
  logic v1, v2, v3;
  logic en1, en2, en3;
  assign en3       = !v3 || out_ready;
  assign en2       = !v2 || en3;
  assign en1       = !v1 || en2;
  assign in_ready  = en1;
  assign out_valid = v3;

  // Stage 1 registers
  logic [SUM_W-1:0] s1_n;
  logic [XW-1:0]    s1_exp;
  logic [LZC_W-1:0] s1_lzc;
  logic             s1_sticky, s1_carry, s1_sign;
  // Stage 2 registers
  logic [SUM_W-1:0] s2_n;
  logic [XW-1:0]    s2_exp;
  logic             s2_sticky, s2_uf, s2_sign;

  // Align: carry-out shifts right by one; otherwise count leading zeros for the left shift.
  logic [SUM_W-1:0] a_n;
  logic [XW-1:0]    a_exp;
  logic [LZC_W-1:0] a_lzc;
  logic             a_sticky;
  always_comb begin
    // NOTE: combinational blocks use blocking assignments with every output defaulted first, so no latch is inferred.
    a_lzc = LZC_W'(SUM_W);
    for (int i = 0; i < SUM_W; i++)
      if (in_sum[i]) a_lzc = LZC_W'(SUM_W - 1 - i);
    if (in_carry) begin
      a_n      = {1'b1, in_sum[SUM_W-1:1]};
      a_sticky = in_sticky | in_sum[0];
      a_exp    = XW'(in_exp) + XW'(1);
    end else begin
      a_n      = in_sum;
      a_sticky = in_sticky;
      a_exp    = XW'(in_exp);
    end
  end

  // Shift: zero detection, underflow flush, then normalizing left shift.
  logic [SUM_W-1:0] b_n;
  logic [XW-1:0]    b_exp;
  logic             b_sticky, b_uf;
  always_comb begin
    b_n      = s1_n;
    b_exp    = s1_exp;
    b_sticky = s1_sticky;
    b_uf     = 1'b0;
    if (!s1_carry) begin
      if (s1_n == '0 && !s1_sticky) begin
        b_exp = '0;
      end else if (XW'(s1_lzc) >= s1_exp) begin
        b_n      = '0;
        b_exp    = '0;
        b_sticky = 1'b0;
        b_uf     = 1'b1;
      end else begin
        b_n   = s1_n << s1_lzc;
        b_exp = s1_exp - XW'(s1_lzc);
      end
    end
  end

  // Round to nearest even; lsb/guard/round sit in n[2:0].
  logic              c_up, c_fcarry, c_ovf, c_inexact;
  logic [FRAC_W-1:0] c_frac_sum, c_frac;
  logic [XW-1:0]     c_exp_r;
  logic [EXP_W-1:0]  c_exp;
  always_comb begin
    c_up                     = s2_n[1] & (s2_n[0] | s2_sticky | s2_n[2]);
    {c_fcarry, c_frac_sum}   = {1'b0, s2_n[SUM_W-2:2]} + (FRAC_W + 1)'(c_up);
    c_exp_r                  = s2_exp + XW'(c_fcarry);
    c_ovf                    = c_exp_r >= EXP_INF;
    c_inexact                = s2_n[1] | s2_n[0] | s2_sticky | s2_uf | c_ovf;
    c_exp                    = c_exp_r[EXP_W-1:0];
    c_frac                   = c_frac_sum;
    if (c_ovf) begin
`ifdef FP_NORM_OVF_SAT_EN
      c_exp  = {{(EXP_W-1){1'b1}}, 1'b0};
      c_frac = '1;
`else
      c_exp  = '1;
      c_frac = '0;
`endif
    end
  end

  // Valid bits and visible outputs are reset; outputs load only with a real beat.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      v3          <= 1'b0;
      out_sign    <= 1'b0;
      out_exp     <= '0;
      out_frac    <= '0;
      out_ovf     <= 1'b0;
      out_uf      <= 1'b0;
      out_inexact <= 1'b0;
    end else begin
      if (en1) v1 <= in_valid;
      if (en2) v2 <= v1;
      if (en3) v3 <= v2;
      if (en3 && v2) begin
        out_sign    <= s2_sign;
        out_exp     <= c_exp;
        out_frac    <= c_frac;
        out_ovf     <= c_ovf;
        out_uf      <= s2_uf;
        out_inexact <= c_inexact;
      end
    end
  end

  // NOTE: datapath stage registers carry no reset; their contents are only consumed under a set valid bit.
  always_ff @(posedge clk) begin
    if (en1 && in_valid) begin
      s1_n      <= a_n;
      s1_exp    <= a_exp;
      s1_lzc    <= a_lzc;
      s1_sticky <= a_sticky;
      s1_carry  <= in_carry;
      s1_sign   <= in_sign;
    end
    if (en2 && v1) begin
      s2_n      <= b_n;
      s2_exp    <= b_exp;
      s2_sticky <= b_sticky;
      s2_uf     <= b_uf;
      s2_sign   <= s1_sign;
    end
  end

endmodule

// File: doc/fp_norm_round.md
# fp_norm_round

Post-add normalize-and-round stage for the floating-point ALU datapath. It consumes the raw significand sum and carry-out produced by the carry-lookahead mantissa adder, together with the pre-add exponent and sign. It normalizes, rounds to nearest-even and adjusts the exponent, producing a packed sign/exponent/fraction result with exception flags. It is a 3-stage valid/ready pipeline with full backpressure.

## Interface
- SUM_W, 51: width of adder sum input; hidden-bit position is SUM_W-1.
- FRAC_W, 48: stored fraction width; must satisfy SUM_W-1-FRAC_W = 2 (guard, round).
- EXP_W, 11: biased exponent width.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat this cycle.
- in_sign  in  1  result sign (passed through).
- in_exp  in  EXP_W  biased exponent before normalization.
- in_carry  in  1  adder carry-out.
- in_sum  in  SUM_W  adder sum.
- in_sticky  in  1  OR of bits shifted out during pre-add alignment.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sign  out  1  result sign.
- out_exp  out  EXP_W  result biased exponent.
- out_frac  out  FRAC_W  result fraction (hidden bit dropped).
- out_ovf  out  1  overflow flag.
- out_uf  out  1  underflow flag (result flushed to zero).
- out_inexact  out  1  inexact flag.

## Operation
- Stage 1 (align):
  - If in_carry=1: n = {1, in_sum[SUM_W-1:1]}, sticky = in_sticky | in_sum[0], exp = in_exp+1 (computed EXP_W+1 wide).
  - Else: n = in_sum, sticky = in_sticky; compute lzc = leading-zero count of in_sum (0..SUM_W; lzc = SUM_W means zero).
- Stage 2 (shift):
  - Non-carry path: if in_sum = 0 and sticky = 0, the result is zero (exp 0, frac 0, no flags).
  - If lzc >= in_exp, the result underflows: flush to zero, uf = 1, inexact = 1.
  - Otherwise n <<= lzc and exp = in_exp - lzc.
- Stage 3 (round):
  - Bit layout: lsb = n[2], guard = n[1], round = n[0].
  - round_up = guard & (round | sticky | lsb).
  - frac = n[SUM_W-2:2] + round_up. A carry out of the fraction sets frac = 0 and exp += 1.
  - inexact = guard | round | sticky.
- Overflow: if final exp >= 2^EXP_W - 1, then ovf = 1 and inexact = 1. Result per Configuration.
- Sign always passes through unchanged, including for zero and overflow results.
- Pipeline control:
  - Each stage holds a valid bit.
  - A stage loads when it is empty or its contents advance in the same cycle.
  - in_ready = !v1 | advance1, where advance chains from out_ready through v3 and v2.
  - No bubbles are inserted; beats never reorder or drop.

## Timing
- Latency: 3 cycles from accepted input (in_valid & in_ready) to out_valid, with out_ready held high.
- Throughput: 1 beat per cycle.
- Stall: while out_valid=1 and out_ready=0, all out_* hold stable. Three beats can be buffered; in_ready deasserts only when all three stages are full and out_ready=0.
- in_ready is combinational from out_ready. No other combinational input-to-output path exists.
- Reset:
  - All valid bits clear on the first clk edge with rst=1. out_valid=0, in_ready=1 during and after reset.
  - out_sign, out_exp, out_frac and all flags reset to 0.
  - Reset mid-stream discards in-flight beats.
- Simultaneous events: a beat accepted in the same cycle the output is consumed proceeds with no stall.

## Configuration
- FP_NORM_OVF_SAT_EN defined: overflow saturates to the largest finite value, exp = 2^EXP_W-2 and frac = all ones.
- FP_NORM_OVF_SAT_EN undefined (default): overflow produces infinity, exp = all ones and frac = 0.
- Flags are identical in both builds.

## Test plan
- in_carry=0, in_sum=1<<50, in_exp=0x400, in_sticky=0, out_ready=1 -> 3 cycles later out_exp=0x400, out_frac=0, all flags 0.
- in_carry=1, in_sum=0, in_exp=0x400 -> out_exp=0x401, out_frac=0, inexact=0. Same case with in_sum=1 -> inexact=1, no round-up.
- in_sum=1<<40, in_exp=0x400 -> out_exp=0x3F6, out_frac=0. Same case with in_exp=5 -> zero result, uf=1, inexact=1.
- Rounding:
  - in_sum=(1<<50)|2: tie with even lsb -> frac=0, inexact=1.
  - in_sum=(1<<50)|6: tie with odd lsb -> frac=2.
  - in_sum=all ones, in_carry=0, in_exp=0x400 -> frac=0, exp=0x401.
- in_carry=1, in_exp=0x7FE -> ovf=1, exp=0x7FF, frac=0. With FP_NORM_OVF_SAT_EN -> exp=0x7FE, frac=all ones.
- Backpressure and reset:
  - Offer 5 consecutive beats while out_ready=0 -> exactly 3 accepted, then in_ready=0. Raising out_ready drains them in order with no loss or duplication.
  - Asserting rst with 3 beats in flight -> out_valid=0 on the next cycle.
